sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 The block SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- Mem_CE  in  1  chip enable, active-low.
- Mem_OE  in  1  output enable (read strobe), active-low.
- Mem_WE  in  1  write enable, active-low.
- Mem_UB  in  1  upper-byte enable [15:8], active-low.
- Mem_LB  in  1  lower-byte enable [7:0], active-low.
- ADDR  in  16  word address; ADDR[7:0] indexes a 256x16 array, ADDR[15:8] ignored.
- Data_to_mem  in  16  write data.
- Data_from_mem  out  16  read data.
- Data_valid  out  1  Data_from_mem holds valid read data this cycle.
- Init_we  in  1  bench preload write strobe.
- Init_addr  in  8  preload address.
- Init_data  in  16  preload data.
- Init_ack  out  1  one-cycle pulse after a preload write is accepted.
- Rd_count  out  16  completed read accesses, saturating.
- Wr_count  out  16  committed writes, saturating.
- Conflict  out  1  sticky error: OE and WE sampled low together with CE low.
REQ-002 Reset SHALL be Reset, asynchronous, active-high; the clock SHALL be Clk.

Function
REQ-003 Storage SHALL be a 256x16 array that is not cleared by Reset.
REQ-004 A selected cycle SHALL be any cycle with Mem_CE=0; while Mem_CE=1, every state SHALL return to IDLE with no write.
REQ-005 The FSM SHALL have the states IDLE, RD_ACTIVE, WR_ARM and WR_DONE.
REQ-006 IDLE transitions:
- selected with OE=0 and WE=1 -> RD_ACTIVE; Rd_count+1.
- selected with WE=0 and OE=1 -> WR_ARM; ADDR and Data_to_mem latched.
- selected with OE=0 and WE=0 -> Conflict set; remain in IDLE.
REQ-007 In RD_ACTIVE:
- Data_from_mem SHALL be registered from mem[ADDR[7:0]] at each edge entering or remaining in RD_ACTIVE.
- Data_valid SHALL be 1, so data is valid in the 2nd and later consecutive cycles of OE low.
- Lanes whose UB or LB is 1 SHALL read as 0x00.
REQ-008 RD_ACTIVE SHALL be held while selected with OE=0 and WE=1, refreshing the data each cycle from the current ADDR; Rd_count SHALL increment only on entry.
REQ-009 RD_ACTIVE exits:
- OE=1 -> IDLE, Data_valid=0.
- WE=0 -> Conflict set, IDLE.
REQ-010 WR_ARM:
- selected with WE=0 at the next edge -> commit the latched data to the latched address, writing only the enabled lanes (UB/LB sampled at commit); Wr_count+1; -> WR_DONE.
- WE=1 -> abort with no write; -> IDLE.
REQ-011 WR_DONE SHALL perform no further write and SHALL remain while WE=0 (one write per WE pulse); WE=1 -> IDLE.
REQ-012 Data_from_mem SHALL hold its last value outside RD_ACTIVE; Data_valid SHALL be 0 outside RD_ACTIVE.
REQ-013 A write committed to address A SHALL be visible to a read of A that begins on the following cycle.
REQ-014 Init_we=1 SHALL write Init_data to mem[Init_addr] at the edge, and Init_ack SHALL pulse in the next cycle, except in a commit cycle.
REQ-015 On a collision with a commit, the commit SHALL win, the preload SHALL be dropped, and no Init_ack SHALL be issued.
REQ-016 Rd_count and Wr_count SHALL saturate at 0xFFFF.
REQ-017 Conflict SHALL clear only on Reset.

Reset
REQ-018 On Reset assertion (asynchronous), the block SHALL:
- enter IDLE;
- set Data_from_mem=0x0000, Data_valid=0, Init_ack=0, Rd_count=0, Wr_count=0, Conflict=0.
REQ-019 Reset asserted in WR_ARM SHALL cause no write; array contents SHALL be preserved across Reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Preload mem[0x10]=0x1234 via Init; CE=0, OE=0 for 2 cycles, ADDR=0x0010 -> 2nd cycle: Data_valid=1, Data_from_mem=0x1234; Rd_count=1.
- WE=0 for 2 cycles, ADDR=0x0020, Data_to_mem=0xBEEF, UB=LB=0; then read 0x20 -> 0xBEEF; Wr_count=1.
- Write 0x00AA to 0x20 holding 0xBEEF with UB=1, LB=0 -> reads 0xBEAA; read with LB=1 -> 0xBE00.
- WE low for only 1 cycle, then WE=1 -> no write, Wr_count unchanged; WE held low 5 cycles -> exactly one write.
- OE=0 and WE=0 with CE=0 -> Conflict=1, no write, no read; Conflict stays 1 until Reset.
- Reset pulsed mid-WR_ARM -> no write, all outputs 0, prior contents intact; Init_we colliding with a commit -> commit data stored, no Init_ack.

Source files
------------

// File: rtl/sram_responder.sv
// Clocked model of an asynchronous 256x16 SRAM as seen by a memory controller:
// registered reads, one byte-lane write per WE pulse, preload port and usage counters.
module sram_responder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_mem,
  output logic [15:0] Data_from_mem,
  output logic        Data_valid,
  input  logic        Init_we,
  input  logic [7:0]  Init_addr,
  input  logic [15:0] Init_data,
  output logic        Init_ack,
  output logic [15:0] Rd_count,
  output logic [15:0] Wr_count,
  output logic        Conflict
);

  typedef enum logic [1:0] {IDLE, RD_ACTIVE, WR_ARM, WR_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] mem [0:255];
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        sel, rd_req, wr_req, clash;
  logic        commit, arm, rd_enter, rd_load;
  logic [15:0] rd_word, rd_lanes;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^ADDR[15:8];

  assign sel    = ~Mem_CE;
  assign rd_req = sel & ~Mem_OE &  Mem_WE;
  assign wr_req = sel &  Mem_OE & ~Mem_WE;
  assign clash  = sel & ~Mem_OE & ~Mem_WE;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A deselect or an OE/WE clash always parks the FSM in IDLE without touching the array.
  always_comb begin
    // NOTE: default assignment first, so no path through this block infers a latch.
    state_nxt = state;
    if (!sel || clash) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_req)      state_nxt = RD_ACTIVE;
          else if (wr_req) state_nxt = WR_ARM;
        end
        RD_ACTIVE: if (!rd_req) state_nxt = IDLE;
        WR_ARM:    state_nxt = Mem_WE ? IDLE : WR_DONE;
        WR_DONE:   if (Mem_WE) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    arm      = (state == IDLE)   && (state_nxt == WR_ARM);
    commit   = (state == WR_ARM) && (state_nxt == WR_DONE);
    rd_enter = (state == IDLE)   && (state_nxt == RD_ACTIVE);
    rd_load  = (state_nxt == RD_ACTIVE);
  end

  assign rd_word  = mem[ADDR[7:0]];
  assign rd_lanes = {Mem_UB ? 8'h00 : rd_word[15:8], Mem_LB ? 8'h00 : rd_word[7:0]};

  // NOTE: the array and the write latch have no reset; contents must survive Reset.
  always_ff @(posedge Clk) begin
    if (arm) begin
      wr_addr <= ADDR[7:0];
      wr_data <= Data_to_mem;
    end
    if (commit) begin
      if (!Mem_UB) mem[wr_addr][15:8] <= wr_data[15:8];
      if (!Mem_LB) mem[wr_addr][7:0]  <= wr_data[7:0];
    end else if (Init_we) begin
      mem[Init_addr] <= Init_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_from_mem <= 16'h0000;
      Data_valid    <= 1'b0;
      Init_ack      <= 1'b0;
      Rd_count      <= 16'h0000;
      Wr_count      <= 16'h0000;
      Conflict      <= 1'b0;
    end else begin
      Data_valid <= rd_load;
      Init_ack   <= Init_we & ~commit;
      if (rd_load)                         Data_from_mem <= rd_lanes;
      if (rd_enter && Rd_count != 16'hFFFF) Rd_count     <= Rd_count + 16'd1;
      if (commit && Wr_count != 16'hFFFF)   Wr_count     <= Wr_count + 16'd1;
      if (clash)                           Conflict      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed scenarios plus random read/write traffic,
// scored against an array model with a queue-based read-data scoreboard.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [15:0] ADDR, Data_to_mem, Data_from_mem;
  logic        Data_valid;
  logic        Init_we;
  logic [7:0]  Init_addr;
  logic [15:0] Init_data;
  logic        Init_ack;
  logic [15:0] Rd_count, Wr_count;
  logic        Conflict;

  sram_responder dut (
    .Clk(Clk), .Reset(Reset),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .ADDR(ADDR), .Data_to_mem(Data_to_mem),
    .Data_from_mem(Data_from_mem), .Data_valid(Data_valid),
    .Init_we(Init_we), .Init_addr(Init_addr), .Init_data(Init_data), .Init_ack(Init_ack),
    .Rd_count(Rd_count), .Wr_count(Wr_count), .Conflict(Conflict)
  );

  always #5 Clk = ~Clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model [0:255];
  bit          known [0:255];
  int          rd_exp = 0;
  int          wr_exp = 0;
  logic [15:0] sb_q [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lanes(input logic [15:0] w, input bit ub, input bit lb);
    return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
  endfunction

  // Monitor: every cycle the DUT flags valid read data must match the oldest expectation.
  always @(negedge Clk) begin
    if (Reset === 1'b0 && Data_valid === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_valid", Data_from_mem, 16'hxxxx);
      else                  check("read_data", Data_from_mem, sb_q.pop_front());
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic go_idle();
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
    step();
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    Init_we = 1'b1; Init_addr = a; Init_data = d;
    step();
    Init_we = 1'b0;
    model[a] = d; known[a] = 1'b1;
    check("init_ack_pulse", {15'd0, Init_ack}, 16'd1);
    step();
    check("init_ack_clear", {15'd0, Init_ack}, 16'd0);
  endtask

  // Holds OE low for n cycles on one word; the DUT shows n valid beats.
  task automatic read_txn(input logic [7:0] a, input bit ub, input bit lb, input int n);
    for (int i = 0; i < n; i++) begin
      Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = ub; Mem_LB = lb;
      ADDR = {8'($urandom), a};
      sb_q.push_back(lanes(model[a], ub, lb));
      step();
    end
    if (n > 0) rd_exp++;
    go_idle();
  endtask

  // Holds WE low for n cycles; the bus changes after the first cycle to prove latching.
  task automatic write_txn(input logic [7:0] a, input logic [15:0] d, input bit ub, input bit lb,
                           input int n);
    for (int i = 0; i < n; i++) begin
      Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = ub; Mem_LB = lb;
      ADDR        = (i == 0) ? {8'($urandom), a} : 16'($urandom);
      Data_to_mem = (i == 0) ? d : 16'($urandom);
      step();
    end
    if (n >= 2) begin
      if (!ub) model[a][15:8] = d[15:8];
      if (!lb) model[a][7:0]  = d[7:0];
      wr_exp++;
    end
    go_idle();
  endtask

  logic [7:0]  ra;
  logic [15:0] rd;

  initial begin
    Reset = 1'b1; Init_we = 1'b0; Init_addr = 8'h00; Init_data = 16'h0000;
    ADDR = 16'h0000; Data_to_mem = 16'h0000;
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    #12;
    check("rst_data", Data_from_mem, 16'h0000);
    check("rst_valid", {15'd0, Data_valid}, 16'd0);
    check("rst_rdcnt", Rd_count, 16'd0);
    check("rst_wrcnt", Wr_count, 16'd0);
    check("rst_conflict", {15'd0, Conflict}, 16'd0);
    check("rst_ack", {15'd0, Init_ack}, 16'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    step();

    // Preload then two-cycle read.
    preload(8'h10, 16'h1234);
    read_txn(8'h10, 1'b0, 1'b0, 2);
    check("rd_count_1", Rd_count, 16'd1);

    // Full write, read back, then upper-lane-masked write and lane-masked read.
    write_txn(8'h20, 16'hBEEF, 1'b0, 1'b0, 2);
    read_txn(8'h20, 1'b0, 1'b0, 2);
    check("wr_count_1", Wr_count, 16'd1);
    write_txn(8'h20, 16'h00AA, 1'b1, 1'b0, 2);
    check("model_beaa", model[8'h20], 16'hBEAA);
    read_txn(8'h20, 1'b0, 1'b0, 2);
    read_txn(8'h20, 1'b0, 1'b1, 3);

    // Short WE pulse aborts; long WE pulse writes exactly once.
    preload(8'h60, 16'h6060);
    write_txn(8'h60, 16'h1111, 1'b0, 1'b0, 1);
    check("abort_wrcnt", Wr_count, 16'(wr_exp));
    read_txn(8'h60, 1'b0, 1'b0, 2);
    write_txn(8'h50, 16'hA5C3, 1'b0, 1'b0, 5);
    check("long_we_wrcnt", Wr_count, 16'(wr_exp));
    read_txn(8'h50, 1'b0, 1'b0, 2);

    // Random traffic; reads favour addresses with a known value.
    for (int t = 0; t < 60; t++) begin
      ra = 8'h80 + 8'($urandom_range(0, 7));
      rd = 16'($urandom);
      if (!known[ra] || $urandom_range(0, 1) == 0) begin
        if (!known[ra]) begin
          write_txn(ra, rd, 1'b0, 1'b0, 2);
          known[ra] = 1'b1;
        end else begin
          write_txn(ra, rd, 1'($urandom), 1'($urandom), $urandom_range(1, 4));
        end
      end else begin
        read_txn(ra, 1'($urandom), 1'($urandom), $urandom_range(1, 4));
      end
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    check("rand_rdcnt", Rd_count, 16'(rd_exp));
    check("rand_wrcnt", Wr_count, 16'(wr_exp));

    // Preload colliding with a commit: commit wins, no ack.
    Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; ADDR = 16'h0040; Data_to_mem = 16'hC0DE;
    step();
    Init_we = 1'b1; Init_addr = 8'h40; Init_data = 16'h7777;
    step();
    Init_we = 1'b0;
    check("collide_no_ack", {15'd0, Init_ack}, 16'd0);
    model[8'h40] = 16'hC0DE; wr_exp++;
    go_idle();
    read_txn(8'h40, 1'b0, 1'b0, 2);
    check("collide_wrcnt", Wr_count, 16'(wr_exp));

    // OE/WE clash: flag only, no read or write, and it stays set.
    Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0020; Data_to_mem = 16'h1111;
    step();
    check("clash_conflict", {15'd0, Conflict}, 16'd1);
    check("clash_valid", {15'd0, Data_valid}, 16'd0);
    check("clash_rdcnt", Rd_count, 16'(rd_exp));
    check("clash_wrcnt", Wr_count, 16'(wr_exp));
    go_idle();
    read_txn(8'h20, 1'b0, 1'b0, 2);
    write_txn(8'h21, 16'h2121, 1'b0, 1'b0, 2);
    check("conflict_sticky", {15'd0, Conflict}, 16'd1);

    // Reset in WR_ARM: no write, outputs cleared, contents kept.
    preload(8'h30, 16'h5A5A);
    Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; ADDR = 16'h0030; Data_to_mem = 16'hFFFF;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; Mem_CE = 1'b1; Mem_WE = 1'b1;
    rd_exp = 0; wr_exp = 0;
    check("rst2_data", Data_from_mem, 16'h0000);
    check("rst2_valid", {15'd0, Data_valid}, 16'd0);
    check("rst2_rdcnt", Rd_count, 16'd0);
    check("rst2_wrcnt", Wr_count, 16'd0);
    check("rst2_conflict", {15'd0, Conflict}, 16'd0);
    check("rst2_ack", {15'd0, Init_ack}, 16'd0);
    step();
    read_txn(8'h30, 1'b0, 1'b0, 2);
    read_txn(8'h10, 1'b0, 1'b0, 2);
    check("post_rst_rdcnt", Rd_count, 16'(rd_exp));
    check("post_rst_wrcnt", Wr_count, 16'd0);

    step();
    check("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
